// File: rtl/lw_writeback_unit_pkg.sv
// Shared types and defaults for the load-word writeback unit: FSM states,
// queue entry layout and timeout counter sizing.
package lw_wb_pkg;

    localparam int LW_M       = 32;
    localparam int LW_N       = 5;
    localparam int LW_QDEPTH  = 2;
    localparam int LW_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lw_state_e;

    typedef struct packed {
        logic [LW_M-1:0] addr;
        logic [LW_N-1:0] rd;
    } lw_entry_t;

    // Counter must be able to represent TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int LW_CW = cnt_width(LW_TIMEOUT);

endpackage

// File: rtl/lw_writeback_unit_if.sv
// Bus bundle for the writeback unit: load issue, data-memory read and
// register-file write port. master = the unit, slave = its environment.
interface lw_writeback_unit_if
    import lw_wb_pkg::*;
#(
    parameter int M = LW_M,
    parameter int N = LW_N
);
    logic         ld_valid;
    logic         ld_ready;
    logic [M-1:0] ld_addr;
    logic [N-1:0] ld_rd;
    logic         mem_req;
    logic [M-1:0] mem_addr;
    logic         mem_ack;
    logic [M-1:0] mem_rdata;
    logic         we_fr;
    logic [N-1:0] wa_fr;
    logic [M-1:0] wd_fr;
    logic         busy;
    logic         err;

    modport master (
        input  ld_valid, ld_addr, ld_rd, mem_ack, mem_rdata,
        output ld_ready, mem_req, mem_addr, we_fr, wa_fr, wd_fr, busy, err
    );

    modport slave (
        output ld_valid, ld_addr, ld_rd, mem_ack, mem_rdata,
        input  ld_ready, mem_req, mem_addr, we_fr, wa_fr, wd_fr, busy, err
    );

endinterface

// File: rtl/lw_writeback_unit_fifo.sv
// Small synchronous request FIFO with registered occupancy count and
// wrapping pointers; QDEPTH must be a power of two.
module lw_req_fifo
    import lw_wb_pkg::*;
#(
    parameter int  QDEPTH = LW_QDEPTH,
    parameter type T      = lw_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

    T              mem_r [QDEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CNT_FULL);
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign rdata  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is free.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/lw_writeback_unit.sv
// Load-word writeback initiator: queues LW requests, reads data memory over
// req/ack with a timeout, then issues a one-cycle register-file write.
module lw_writeback_unit
    import lw_wb_pkg::*;
#(
    parameter int M       = LW_M,
    parameter int N       = LW_N,
    parameter int QDEPTH  = LW_QDEPTH,
    parameter int TIMEOUT = LW_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    lw_writeback_unit_if.master bus
);
    typedef struct packed {
        logic [M-1:0] addr;
        logic [N-1:0] rd;
    } entry_t;

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    lw_state_e    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [M-1:0] mem_addr_r, mem_addr_s;
    logic         we_fr_r, we_fr_s;
    logic [N-1:0] wa_fr_r, wa_fr_s;
    logic [M-1:0] wd_fr_r, wd_fr_s;
    logic         err_r, err_s;
    logic         push_s, pop_s, full_s, empty_s;
    entry_t       head_s, push_entry_s;

    assign push_s       = bus.ld_valid & ~full_s;
    assign push_entry_s = '{addr: bus.ld_addr, rd: bus.ld_rd};

    lw_req_fifo #(
        .QDEPTH (QDEPTH),
        .T      (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state, queue pop and registered-output next values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        mem_addr_s = mem_addr_r;
        we_fr_s    = 1'b0;
        wa_fr_s    = wa_fr_r;
        wd_fr_s    = wd_fr_r;
        err_s      = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (empty_s) begin
                    state_s = IDLE;
                end else if (head_s.addr[1:0] != 2'b00) begin
                    err_s = 1'b1;
                    pop_s = 1'b1;
                end else begin
                    mem_addr_s = head_s.addr;
                    cnt_s      = {CW{1'b0}};
                    state_s    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_s = WB;
                    // The write is launched here so it is visible during WB.
                    if (head_s.rd != {N{1'b0}}) begin
                        we_fr_s = 1'b1;
                        wa_fr_s = head_s.rd;
                        wd_fr_s = bus.mem_rdata;
                    end else begin
                        we_fr_s = 1'b0;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    err_s   = 1'b1;
                    pop_s   = 1'b1;
                    state_s = IDLE;
                end else if (cnt_r < CNT_LAST) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            WB: begin
                pop_s   = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            mem_addr_r <= {M{1'b0}};
            we_fr_r    <= 1'b0;
            wa_fr_r    <= {N{1'b0}};
            wd_fr_r    <= {M{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            mem_addr_r <= mem_addr_s;
            we_fr_r    <= we_fr_s;
            wa_fr_r    <= wa_fr_s;
            wd_fr_r    <= wd_fr_s;
            err_r      <= err_s;
        end
    end

    assign bus.ld_ready = ~full_s;
    assign bus.mem_req  = (state_r == REQ);
    assign bus.mem_addr = mem_addr_r;
    assign bus.we_fr    = we_fr_r;
    assign bus.wa_fr    = wa_fr_r;
    assign bus.wd_fr    = wd_fr_r;
    assign bus.err      = err_r;
    assign bus.busy     = ~empty_s | (state_r != IDLE);

endmodule

// File: tb/tb_lw_writeback_unit.sv
// Scoreboard bench for lw_writeback_unit: stimulus pushes expected outcomes,
// a memory responder plays back per-load ack delays, a monitor checks events.
module tb_lw_writeback_unit;
    import lw_wb_pkg::*;

    localparam int TMO = LW_TIMEOUT;
    localparam int K_WRITE = 0;
    localparam int K_MIS   = 1;
    localparam int K_TMO   = 2;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    lw_writeback_unit_if bus ();

    lw_writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   dq[$];
    logic stray = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Memory contents as seen by the bench.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Offer one load (called at a negedge); the model records its outcome.
    task automatic issue(input logic [31:0] a, input logic [4:0] r, input int d);
        int   guard = 0;
        exp_t e;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_rd    = r;
        while (!bus.ld_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            chk("issue_accept_timeout", 64'(bus.ld_ready), 64'd1);
        end else begin
            e.rd   = r;
            e.data = memfn(a);
            if (a[1:0] != 2'b00) begin
                e.kind = K_MIS;
                exp_q.push_back(e);
            end else begin
                dq.push_back(d);
                if (d >= TMO) begin
                    e.kind = K_TMO;
                    exp_q.push_back(e);
                end else if (r != 5'd0) begin
                    e.kind = K_WRITE;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    // Memory responder: acks after the delay recorded for each request.
    initial begin
        int  d = 0;
        int  w = 0;
        bit  active = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active      = 1'b0;
                bus.mem_ack = 1'b0;
            end else if (stray) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
            end else if (bus.mem_req) begin
                if (!active) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_mem_req", 64'(dq.size()), 64'd1);
                        d = 1000;
                    end else begin
                        d = dq.pop_front();
                    end
                    active = 1'b1;
                    w = 0;
                end
                if (w == d) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = memfn(bus.mem_addr);
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
                w++;
            end else begin
                active        = 1'b0;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Monitor: every write or err pulse is matched against the scoreboard.
    initial begin
        int   run = 0;
        int   last_run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (bus.mem_req) begin
                    run++;
                end else if (run != 0) begin
                    last_run = run;
                    run = 0;
                end
                if (bus.we_fr) begin
                    chk("write_rd_nonzero", 64'(bus.wa_fr != 5'd0), 64'd1);
                    if (exp_q.size() == 0) begin
                        chk("write_expected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_kind", 64'(e.kind), 64'(K_WRITE));
                        chk("write_wa", 64'(bus.wa_fr), 64'(e.rd));
                        chk("write_wd", 64'(bus.wd_fr), 64'(e.data));
                    end
                end
                if (bus.err) begin
                    chk("err_no_mem_req", 64'(bus.mem_req), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("err_expected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("err_kind_is_error", 64'(e.kind != K_WRITE), 64'd1);
                        if (e.kind == K_TMO) begin
                            chk("timeout_req_cycles", 64'(last_run), 64'(TMO));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || bus.busy); i++) begin
            @(negedge clk);
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_not_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
        chk({tag, "_we_fr"}, 64'(bus.we_fr), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'd1);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_wa_fr"}, 64'(bus.wa_fr), 64'd0);
        chk({tag, "_wd_fr"}, 64'(bus.wd_fr), 64'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [31:0] a;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'd0;
        bus.ld_rd    = 5'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Single load with immediate ack: latency k+1 / k+2 / busy drop k+3.
        issue(32'h0000_0010, 5'd5, 0);
        chk("single_req_k", 64'(bus.mem_req), 64'd0);
        @(negedge clk);
        chk("single_req_k1", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        chk("single_we_k2", 64'(bus.we_fr), 64'd1);
        chk("single_wd_k2", 64'(bus.wd_fr), 64'hDEAD_BEEF);
        chk("single_wa_k2", 64'(bus.wa_fr), 64'd5);
        @(negedge clk);
        chk("single_busy_k3", 64'(bus.busy), 64'd0);
        chk("single_we_k3", 64'(bus.we_fr), 64'd0);
        chk("single_wa_hold", 64'(bus.wa_fr), 64'd5);

        // Backpressure: two pushes fill the queue, the third waits.
        issue(32'h0000_0100, 5'd1, 4);
        issue(32'h0000_0104, 5'd2, 4);
        chk("full_ld_ready", 64'(bus.ld_ready), 64'd0);
        issue(32'h0000_0108, 5'd3, 4);
        wait_idle(200);

        // rd=0 pops silently, misaligned errors, then the unit carries on.
        issue(32'h0000_0200, 5'd0, 1);
        issue(32'h0000_0013, 5'd9, 0);
        issue(32'h0000_0204, 5'd4, 0);
        wait_idle(200);

        // Timeout, then ack in the last permitted cycle, then a normal load.
        issue(32'h0000_0300, 5'd7, 1000);
        issue(32'h0000_0304, 5'd8, 2);
        wait_idle(200);
        issue(32'h0000_0308, 5'd10, TMO - 1);
        issue(32'h0000_030C, 5'd11, 0);
        wait_idle(200);

        // Asynchronous reset with a request outstanding and one queued.
        issue(32'h0000_0400, 5'd12, 1000);
        issue(32'h0000_0404, 5'd13, 1000);
        @(negedge clk);
        chk("pre_reset_mem_req", 64'(bus.mem_req), 64'd1);
        #2 rst = 1'b1;
        exp_q.delete();
        dq.delete();
        #1 chk("async_reset_mem_req", 64'(bus.mem_req), 64'd0);
        chk("async_reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("post_reset");
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", 64'(bus.busy), 64'd0);

        // Ten aligned loads with short random ack delays: pointers wrap.
        for (int i = 0; i < 10; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            issue(a, 5'($urandom_range(1, 31)), $urandom_range(0, 5));
        end
        wait_idle(1000);

        // Random mix of misaligned, rd=0, timeouts and boundary delays.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 5))
                0:       issue(a, 5'd0, $urandom_range(0, 3));
                1:       issue(a, 5'($urandom_range(1, 31)), 1000);
                2:       issue(a, 5'($urandom_range(1, 31)), TMO - 1);
                default: issue(a, 5'($urandom_range(1, 31)), $urandom_range(0, 6));
            endcase
        end
        wait_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lw_writeback_unit.md
Name: lw_writeback_unit

Overview:
- Write-side initiator for the datapath register file: accepts load-word requests (address, destination register), reads data memory over a req/ack handshake, then drives the register file write port (we_fr, wa_fr, wd_fr) for one cycle.
- A 2-entry request queue decouples issue from memory latency.
- Sits between the LW decode/issue stage, data memory and the register file.

Parameters:
- M, 32, data/address width (matches register file word width)
- N, 5, register address width
- QDEPTH, 2, request queue entries (power of two, >=2)
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before abort (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ld_valid  in  1  load request valid
- ld_ready  out  1  queue can accept (not full)
- ld_addr  in  M  byte address of load
- ld_rd  in  N  destination register
- mem_req  out  1  memory read request
- mem_addr  out  M  memory address, stable while mem_req=1
- mem_ack  in  1  memory read data valid
- mem_rdata  in  M  memory read data
- we_fr  out  1  register file write enable
- wa_fr  out  N  register file write address
- wd_fr  out  M  register file write data
- busy  out  1  queue non-empty or FSM not IDLE
- err  out  1  one-cycle pulse: misaligned address or timeout

Behaviour:
- Reset (async, active-high): queue emptied; FSM=IDLE; timeout counter=0; mem_req, we_fr, err, busy = 0; mem_addr, wa_fr, wd_fr = 0; ld_ready=1 after reset deasserts. Any outstanding memory transaction is abandoned. A mem_ack arriving after reset is ignored.
- Queue push: on ld_valid & ld_ready at a rising edge.
  - ld_ready = !full, computed from registered count only; no same-cycle bypass of a pop.
  - ld_valid while full is ignored; the source must hold the request.
- Queue pop: only in the WB state, or on an abort.
  - Simultaneous push and pop while not full updates both; the count is unchanged.
- FSM states: IDLE, REQ, WB.
  - IDLE: if queue is non-empty, inspect the head entry.
    - head ld_addr[1:0] != 0: pulse err, pop, stay IDLE, no write.
    - otherwise: register mem_addr = head addr, clear counter, go REQ.
  - REQ: mem_req=1 and mem_addr held.
    - mem_ack=1: capture mem_rdata, go WB.
    - no ack with counter == TIMEOUT-1: pulse err, pop, mem_req drops next cycle, go IDLE, no write.
    - else: increment counter.
  - WB: we_fr=1 for exactly one cycle with wa_fr=head rd and wd_fr=captured data, then pop and go IDLE.
    - If head rd == 0, we_fr stays 0: register 0 is never written; the pop still occurs.
- we_fr, wa_fr and wd_fr are registered.
  - wa_fr and wd_fr hold their last value when we_fr=0.
- Latency:
  - Request accepted at edge k into an empty idle unit: mem_req=1 from cycle k+1.
  - With mem_ack in the first REQ cycle: we_fr=1 in cycle k+2.
  - Minimum back-to-back throughput: one load per 3 cycles.
- mem_ack outside REQ is ignored.
- The counter saturates; it does not wrap.
- busy = (count != 0) | (state != IDLE).

Decomposition:
- Package lw_wb_pkg:
  - state enum {IDLE, REQ, WB}
  - queue entry struct {addr[M], rd[N]}
  - default widths
  - TIMEOUT counter width computed as $clog2(TIMEOUT+1)
- Sub-module lw_req_fifo: synchronous FIFO, QDEPTH entries, registered count, wrapping read/write pointers, full/empty flags, async active-high reset.

Test Plan:
- Single load: ld_addr=0x10, ld_rd=5, mem_ack in the first REQ cycle with rdata=0xDEADBEEF -> mem_req 1 cycle after accept; we_fr=1, wa_fr=5, wd_fr=0xDEADBEEF the following cycle; busy falls next cycle.
- Queue full/backpressure: push 3 loads back-to-back with mem_ack held low for 4 cycles -> ld_ready=0 after 2 pushes; third held until WB pop; three writes occur in order rd 1, 2, 3.
- rd=0 and misaligned: load to rd=0 -> we_fr never asserts, queue pops. ld_addr=0x13 -> err pulses 1 cycle, no mem_req, no write.
- Timeout: mem_ack never asserted -> mem_req high for exactly TIMEOUT=15 cycles, err pulse, no write; the next queued load then proceeds normally.
- Reset mid-operation: assert rst during REQ with 2 entries queued -> mem_req=0 immediately (async); after release busy=0, ld_ready=1; a stray mem_ack produces no write.
- Wrap-around: 10 sequential loads with random ack delay 0–5 -> FIFO pointers wrap; all 10 writes match a reference model in order.
